// File: rtl/symmetrical_pwm_multi_pkg.sv
// Purpose : shared encodings for the multi-channel centre-aligned PWM block.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package symmetrical_pwm_multi_pkg;

  // Output-enable state machine
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_TRIPPED  = 2'd3
  } en_state_t;

  // Per-channel override codes
  localparam logic [1:0] OVR_NORMAL = 2'b00;  // follow the compare result
  localparam logic [1:0] OVR_HIGH   = 2'b01;  // force high side on
  localparam logic [1:0] OVR_LOW    = 2'b10;  // force low side on
  localparam logic [1:0] OVR_OFF    = 2'b11;  // both sides off, no dead-time

endpackage

// File: rtl/symmetrical_pwm_multi_deadtime.sv
// Purpose : one complementary output pair with rising-edge dead-time insertion.
// Latency : 1 cycle raw->pwm, plus deadtime_i cycles on each turn-on.
// Backpr. : none; free-running, clear_i/force_off_i switch both sides off next cycle.
// Ports   : clk_i, rst_ni (sync, active low); raw_i desired high-side state;
//           force_off_i / clear_i drop both sides and restart dead-time;
//           deadtime_i turn-on delay in cycles; pwm_o {low_side, high_side}.
module symmetrical_pwm_multi_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            raw_i,
  input  logic            force_off_i,
  input  logic            clear_i,
  input  logic [DT_W-1:0] deadtime_i,
  output logic [1:0]      pwm_o
);

  logic            raw_q;
  logic [DT_W-1:0] cnt_q;
  logic [DT_W-1:0] cnt_nxt;
  logic            ready;

  // cnt counts cycles raw has been stable; any raw edge restarts it, so a
  // raw pulse shorter than the dead-time never turns its side on.
  always_comb begin
    cnt_nxt = cnt_q;
    if (raw_i != raw_q) begin
      cnt_nxt = '0;
    end else if (cnt_q < deadtime_i) begin
      cnt_nxt = cnt_q + 1'b1;
    end
    ready = (cnt_nxt >= deadtime_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_q <= 1'b0;
      cnt_q <= '0;
      pwm_o <= 2'b00;
    end else if (clear_i || force_off_i) begin
      raw_q <= raw_i;
      cnt_q <= '0;
      pwm_o <= 2'b00;
    end else begin
      raw_q <= raw_i;
      cnt_q <= cnt_nxt;
      // turn-off is immediate because the side leaving follows raw directly
      pwm_o <= {~raw_i & ready, raw_i & ready};
    end
  end

endmodule

// File: rtl/symmetrical_pwm_multi.sv
// Purpose : N-channel centre-aligned PWM with shadow duty, dead-time, enable FSM, trip.
// Latency : 2 cycles counter->PWM_o (compare reg + output reg) plus dead-time on turn-on.
// Backpr. : none; trip_i forces PWM_o to 0 on the next cycle regardless of state.
// Ports   : clk_i, rst_ni (sync, active low); local_counter_i/current_period_i/
//           sync_phase_i shared triangular timebase; duty_i per-channel compare;
//           deadtime_i shared dead-time; enable_i, trip_i, override_i control;
//           PWM_o {low,high} per channel; enabled_o in RUNNING; load_strobe_o shadow load.
module symmetrical_pwm_multi
  import symmetrical_pwm_multi_pkg::*;
#(
  parameter int CH_NUM        = 4,
  parameter int CNT_W         = 16,
  parameter int DT_W          = 8,
  parameter bit DOUBLE_UPDATE = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CNT_W-1:0]        local_counter_i,
  input  logic [CNT_W-1:0]        current_period_i,
  input  logic                    sync_phase_i,
  input  logic [CH_NUM*CNT_W-1:0] duty_i,
  input  logic [DT_W-1:0]         deadtime_i,
  input  logic                    enable_i,
  input  logic                    trip_i,
  input  logic [CH_NUM*2-1:0]     override_i,
  output logic [CH_NUM*2-1:0]     PWM_o,
  output logic                    enabled_o,
  output logic                    load_strobe_o
);

  logic              sync_q;
  logic              period_start;
  logic              peak;
  logic              load;
  logic              dt_clear;
  logic [CNT_W-1:0]  shadow_q [CH_NUM];
  logic [CNT_W-1:0]  act_duty [CH_NUM];
  logic [CH_NUM-1:0] raw_q;
  en_state_t         state_q;
  en_state_t         state_nxt;

  assign period_start = sync_phase_i & ~sync_q;
  assign peak         = ~sync_phase_i & sync_q;
  assign load         = period_start | (DOUBLE_UPDATE & peak);

  // The load cycle already compares against the incoming duty, so every
  // sample of a half-period uses one and the same duty value.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      act_duty[k] = load ? duty_i[k*CNT_W +: CNT_W] : shadow_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q        <= 1'b0;
      state_q       <= ST_DISABLED;
      load_strobe_o <= 1'b0;
      raw_q         <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      sync_q        <= sync_phase_i;
      state_q       <= state_nxt;
      load_strobe_o <= load;
      for (int k = 0; k < CH_NUM; k++) begin
        shadow_q[k] <= act_duty[k];
        // duty above the peak is 100 % even if the counter overshoots
        raw_q[k]    <= (act_duty[k] > current_period_i) ||
                       (local_counter_i < act_duty[k]);
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_DISABLED: begin
        if (trip_i)        state_nxt = ST_TRIPPED;
        else if (enable_i) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (trip_i)            state_nxt = ST_TRIPPED;
        else if (!enable_i)    state_nxt = ST_DISABLED;
        else if (period_start) state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (trip_i)                         state_nxt = ST_TRIPPED;
        else if (period_start && !enable_i) state_nxt = ST_DISABLED;
      end
      ST_TRIPPED: begin
        if (!trip_i && !enable_i) state_nxt = ST_DISABLED;
      end
      default: state_nxt = ST_DISABLED;
    endcase
  end

  assign enabled_o = (state_q == ST_RUNNING);

  // Clearing on the next state lets a trip blank the outputs one cycle
  // after trip_i, without waiting for the state register.
  assign dt_clear = (state_nxt != ST_RUNNING);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [1:0] ovr;
    logic       raw_eff;

    assign ovr = override_i[2*k +: 2];

    always_comb begin
      raw_eff = raw_q[k];
      if (ovr == OVR_HIGH)     raw_eff = 1'b1;
      else if (ovr == OVR_LOW) raw_eff = 1'b0;
    end

    symmetrical_pwm_multi_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .raw_i       (raw_eff),
      .force_off_i (ovr == OVR_OFF),
      .clear_i     (dt_clear),
      .deadtime_i  (deadtime_i),
      .pwm_o       (PWM_o[2*k +: 2])
    );
  end

endmodule
